// File: rtl/bp_be_pkg.sv
// ---------------------------------------------------------------------------
// bp_be_pkg
//   Shared types for the backend branch feedback generator:
//     - bp_params_e            : processor configuration selector
//     - bp_vaddr_width()       : virtual address width for a configuration
//     - bp_metadata_width()    : forwarded branch metadata width
//     - md_site_*_bit_lp       : positions of the site flags inside metadata
//     - bp_be_fbgen_state_e    : feedback generator FSM states
//     - DECLARE_BP_BE_ATTABOY_ENTRY_S macro : attaboy queue entry struct
// ---------------------------------------------------------------------------

// Declares bp_be_attaboy_entry_s in the scope where it is expanded, so the
// struct widths follow the caller's configuration.
`define DECLARE_BP_BE_ATTABOY_ENTRY_S(vaddr_width_mp, metadata_width_mp) \
  typedef struct packed {                                                  \
    logic [vaddr_width_mp-1:0]    npc;                                     \
    logic [metadata_width_mp-1:0] metadata;                                \
    logic                         taken;                                   \
    logic                         ntaken;                                  \
  } bp_be_attaboy_entry_s;

`define BP_BE_ATTABOY_ENTRY_WIDTH(vaddr_width_mp, metadata_width_mp) \
  ((vaddr_width_mp) + (metadata_width_mp) + 2)

package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0,
    e_bp_sv32_cfg    = 1'b1
  } bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_sv32_cfg) ? 32 : 39;
  endfunction

  function automatic int bp_metadata_width(bp_params_e cfg);
    return (cfg == e_bp_sv32_cfg) ? 20 : 24;
  endfunction

  // The frontend places its site classification in the low metadata bits;
  // the remaining bits are opaque to the backend and only passed through.
  localparam int md_site_br_bit_lp   = 0;
  localparam int md_site_jal_bit_lp  = 1;
  localparam int md_site_jalr_bit_lp = 2;

  typedef enum logic [1:0] {
    e_fbgen_reset     = 2'd0,
    e_fbgen_wait_init = 2'd1,
    e_fbgen_run       = 2'd2
  } bp_be_fbgen_state_e;

endpackage

// File: rtl/bp_be_attaboy_fifo.sv
// ---------------------------------------------------------------------------
// bp_be_attaboy_fifo
//   Single-read single-write FIFO with a valid/yumi output handshake.
//   A write while full is accepted only if a pop happens in the same cycle;
//   otherwise the write is ignored and the caller treats it as a drop.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset (empties FIFO)
//   v_i, data_i      : write request and data
//   full_o           : FIFO holds els_p entries
//   v_o, data_o      : head valid and head data (held until yumi_i)
//   yumi_i           : pop the head this cycle
// ---------------------------------------------------------------------------
module bp_be_attaboy_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp:0] full_cnt_lp = (ptr_w_lp+1)'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [ptr_w_lp:0]   count_q;
  logic                enq, deq;

  assign full_o = (count_q == full_cnt_lp);
  assign v_o    = (count_q != '0);
  assign deq    = yumi_i & v_o;
  // A pop in the same cycle frees the slot the write needs.
  assign enq    = v_i & (~full_o | deq);
  assign data_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wptr_q <= wptr_q + ptr_w_lp'(1);
      if (deq) rptr_q <= rptr_q + ptr_w_lp'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + (ptr_w_lp+1)'(1);
        2'b01:   count_q <= count_q - (ptr_w_lp+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read once the count covers it.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_be_br_feedback_gen.sv
// ---------------------------------------------------------------------------
// bp_be_br_feedback_gen
//   Turns committed control-flow outcomes into frontend feedback:
//     - redirects (mispredicts, or trap/CSR/fence redirects) as a registered
//       one-cycle pulse, external redirects taking priority;
//     - attaboys (correct predictions) queued in a FIFO and released once the
//       frontend predictor has finished initialising.
// Ports:
//   clk_i, reset_n_i          : clock, asynchronous active-low reset
//   fe_init_done_i            : frontend predictor initialisation complete
//   commit_*_i                : committed instruction outcome
//   ext_redirect_v_i/_pc_i    : external redirect request
//   redirect_*_o              : registered redirect to the frontend
//   attaboy_*_o, attaboy_yumi_i : attaboy head and pop handshake
//   attaboy_drop_cnt_o        : saturating dropped-attaboy count
// Configuration:
//   BP_BE_ATTABOY_DROP_CNT_EN : adds attaboy_drop_cnt_o and its counter;
//                               without it dropped attaboys vanish silently.
// ---------------------------------------------------------------------------
module bp_be_br_feedback_gen
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int attaboy_els_p = 4,
  parameter int drop_cnt_width_p = 8,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int branch_metadata_fwd_width_p = bp_metadata_width(bp_params_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   fe_init_done_i,
  input  logic                                   commit_v_i,
  input  logic [vaddr_width_p-1:0]               commit_npc_i,
  input  logic [branch_metadata_fwd_width_p-1:0] commit_br_metadata_fwd_i,
  input  logic                                   commit_taken_i,
  input  logic                                   commit_mispredict_i,
  input  logic                                   commit_nonbr_i,
  input  logic                                   ext_redirect_v_i,
  input  logic [vaddr_width_p-1:0]               ext_redirect_pc_i,
  output logic                                   redirect_v_o,
  output logic [vaddr_width_p-1:0]               redirect_pc_o,
  output logic                                   redirect_br_v_o,
  output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
  output logic                                   redirect_br_taken_o,
  output logic                                   redirect_br_ntaken_o,
  output logic                                   redirect_br_nonbr_o,
  output logic                                   attaboy_v_o,
  output logic [vaddr_width_p-1:0]               attaboy_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
  output logic                                   attaboy_taken_o,
  output logic                                   attaboy_ntaken_o,
  input  logic                                   attaboy_yumi_i
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
  ,output logic [drop_cnt_width_p-1:0]           attaboy_drop_cnt_o
`endif
);

  `DECLARE_BP_BE_ATTABOY_ENTRY_S(vaddr_width_p, branch_metadata_fwd_width_p)
  localparam int entry_width_lp =
    `BP_BE_ATTABOY_ENTRY_WIDTH(vaddr_width_p, branch_metadata_fwd_width_p);

  if (attaboy_els_p < 2 || (attaboy_els_p & (attaboy_els_p - 1)) != 0) begin : g_bad_els
    $error("attaboy_els_p must be a power of two and at least 2");
  end
  if (drop_cnt_width_p < 1) begin : g_bad_cnt
    $error("drop_cnt_width_p must be at least 1");
  end

  bp_be_fbgen_state_e state_q, state_d;
  logic redirect_en, enq_en, deq_en;

  logic site_br, site_jal, site_jalr;
  assign site_br   = commit_br_metadata_fwd_i[md_site_br_bit_lp];
  assign site_jal  = commit_br_metadata_fwd_i[md_site_jal_bit_lp];
  assign site_jalr = commit_br_metadata_fwd_i[md_site_jalr_bit_lp];

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_fbgen_reset;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_fbgen_reset:     state_d = e_fbgen_wait_init;
      e_fbgen_wait_init: if (fe_init_done_i) state_d = e_fbgen_run;
      e_fbgen_run:       state_d = e_fbgen_run;
      default:           state_d = e_fbgen_reset;
    endcase
  end

  // Attaboys may be collected before the frontend is ready, but are only
  // presented to it once it has finished initialising.
  always_comb begin
    redirect_en = 1'b0;
    enq_en      = 1'b0;
    deq_en      = 1'b0;
    case (state_q)
      e_fbgen_wait_init: begin
        redirect_en = 1'b1;
        enq_en      = 1'b1;
      end
      e_fbgen_run: begin
        redirect_en = 1'b1;
        enq_en      = 1'b1;
        deq_en      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Redirect ----------------
  logic                                   redirect_v_q, redirect_v_d;
  logic [vaddr_width_p-1:0]               redirect_pc_q, redirect_pc_d;
  logic                                   br_v_q, br_v_d;
  logic [branch_metadata_fwd_width_p-1:0] br_md_q, br_md_d;
  logic                                   br_taken_q, br_taken_d;
  logic                                   br_ntaken_q, br_ntaken_d;
  logic                                   br_nonbr_q, br_nonbr_d;

  // External redirects override a simultaneous mispredict entirely. Idle
  // cycles zero the payload so it never carries a stale redirect.
  always_comb begin
    redirect_v_d  = 1'b0;
    redirect_pc_d = '0;
    br_v_d        = 1'b0;
    br_md_d       = '0;
    br_taken_d    = 1'b0;
    br_ntaken_d   = 1'b0;
    br_nonbr_d    = 1'b0;
    if (redirect_en) begin
      if (ext_redirect_v_i) begin
        redirect_v_d  = 1'b1;
        redirect_pc_d = ext_redirect_pc_i;
      end else if (commit_v_i && commit_mispredict_i) begin
        redirect_v_d  = 1'b1;
        redirect_pc_d = commit_npc_i;
        br_v_d        = 1'b1;
        br_md_d       = commit_br_metadata_fwd_i;
        br_taken_d    = commit_taken_i & ~commit_nonbr_i;
        br_ntaken_d   = ~commit_taken_i & ~commit_nonbr_i & site_br;
        br_nonbr_d    = commit_nonbr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_v_q        <= 1'b0;
      br_md_q       <= '0;
      br_taken_q    <= 1'b0;
      br_ntaken_q   <= 1'b0;
      br_nonbr_q    <= 1'b0;
    end else begin
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
      br_v_q        <= br_v_d;
      br_md_q       <= br_md_d;
      br_taken_q    <= br_taken_d;
      br_ntaken_q   <= br_ntaken_d;
      br_nonbr_q    <= br_nonbr_d;
    end
  end

  assign redirect_v_o               = redirect_v_q;
  assign redirect_pc_o              = redirect_pc_q;
  assign redirect_br_v_o            = br_v_q;
  assign redirect_br_metadata_fwd_o = br_md_q;
  assign redirect_br_taken_o        = br_taken_q;
  assign redirect_br_ntaken_o       = br_ntaken_q;
  assign redirect_br_nonbr_o        = br_nonbr_q;

  // ---------------- Attaboy queue ----------------
  bp_be_attaboy_entry_s enq_entry, head;
  logic [entry_width_lp-1:0] fifo_data;
  logic enq_v, fifo_full, fifo_v, fifo_yumi;

  assign enq_v = enq_en & commit_v_i & ~commit_mispredict_i
               & (site_br | site_jal | site_jalr);

  assign enq_entry.npc      = commit_npc_i;
  assign enq_entry.metadata = commit_br_metadata_fwd_i;
  assign enq_entry.taken    = commit_taken_i;
  assign enq_entry.ntaken   = ~commit_taken_i & site_br;

  bp_be_attaboy_fifo #(
    .els_p   (attaboy_els_p),
    .width_p (entry_width_lp)
  ) attaboy_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (enq_v),
    .data_i    (enq_entry),
    .full_o    (fifo_full),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .yumi_i    (fifo_yumi)
  );

  assign head        = fifo_data;
  assign attaboy_v_o = fifo_v & deq_en;
  assign fifo_yumi   = attaboy_yumi_i & attaboy_v_o;

  // Payload is zeroed whenever the head is not offered, so reset and an
  // empty queue both present all-zero outputs.
  assign attaboy_pc_o              = attaboy_v_o ? head.npc      : '0;
  assign attaboy_br_metadata_fwd_o = attaboy_v_o ? head.metadata : '0;
  assign attaboy_taken_o           = attaboy_v_o & head.taken;
  assign attaboy_ntaken_o          = attaboy_v_o & head.ntaken;

`ifdef BP_BE_ATTABOY_DROP_CNT_EN
  logic attaboy_drop;
  logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

  // A write is lost only when full and no pop frees a slot this cycle.
  assign attaboy_drop = enq_v & fifo_full & ~fifo_yumi;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (attaboy_drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign attaboy_drop_cnt_o = drop_cnt_q;
`else
  logic fifo_full_unused;
  assign fifo_full_unused = fifo_full;
`endif

  // The consumer must only pop an offered head.
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   attaboy_yumi_i |-> attaboy_v_o);

endmodule

// File: tb/tb_bp_be_br_feedback_gen.sv
// ---------------------------------------------------------------------------
// tb_bp_be_br_feedback_gen
//   Directed self-checking bench for bp_be_br_feedback_gen with default
//   parameters (39-bit vaddr, 24-bit metadata, 4-entry attaboy queue).
//   Drop count checks are compiled in when BP_BE_ATTABOY_DROP_CNT_EN is set.
// ---------------------------------------------------------------------------
module tb_bp_be_br_feedback_gen;
  import bp_be_pkg::*;

  localparam int VW = bp_vaddr_width(e_bp_default_cfg);
  localparam int MW = bp_metadata_width(e_bp_default_cfg);

  localparam logic [MW-1:0] MD_BR   = 24'h000001;
  localparam logic [MW-1:0] MD_JAL  = 24'h000002;
  localparam logic [MW-1:0] MD_NONE = 24'h000000;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          fe_init_done_i;
  logic          commit_v_i;
  logic [VW-1:0] commit_npc_i;
  logic [MW-1:0] commit_br_metadata_fwd_i;
  logic          commit_taken_i, commit_mispredict_i, commit_nonbr_i;
  logic          ext_redirect_v_i;
  logic [VW-1:0] ext_redirect_pc_i;
  logic          redirect_v_o;
  logic [VW-1:0] redirect_pc_o;
  logic          redirect_br_v_o;
  logic [MW-1:0] redirect_br_metadata_fwd_o;
  logic          redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o;
  logic          attaboy_v_o;
  logic [VW-1:0] attaboy_pc_o;
  logic [MW-1:0] attaboy_br_metadata_fwd_o;
  logic          attaboy_taken_o, attaboy_ntaken_o;
  logic          attaboy_yumi_i;
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
  logic [7:0]    attaboy_drop_cnt_o;
`endif

  int checkCount = 0;
  int errorCount = 0;

  bp_be_br_feedback_gen dut (
    .clk_i                      (clk_i),
    .reset_n_i                  (reset_n_i),
    .fe_init_done_i             (fe_init_done_i),
    .commit_v_i                 (commit_v_i),
    .commit_npc_i               (commit_npc_i),
    .commit_br_metadata_fwd_i   (commit_br_metadata_fwd_i),
    .commit_taken_i             (commit_taken_i),
    .commit_mispredict_i        (commit_mispredict_i),
    .commit_nonbr_i             (commit_nonbr_i),
    .ext_redirect_v_i           (ext_redirect_v_i),
    .ext_redirect_pc_i          (ext_redirect_pc_i),
    .redirect_v_o               (redirect_v_o),
    .redirect_pc_o              (redirect_pc_o),
    .redirect_br_v_o            (redirect_br_v_o),
    .redirect_br_metadata_fwd_o (redirect_br_metadata_fwd_o),
    .redirect_br_taken_o        (redirect_br_taken_o),
    .redirect_br_ntaken_o       (redirect_br_ntaken_o),
    .redirect_br_nonbr_o        (redirect_br_nonbr_o),
    .attaboy_v_o                (attaboy_v_o),
    .attaboy_pc_o               (attaboy_pc_o),
    .attaboy_br_metadata_fwd_o  (attaboy_br_metadata_fwd_o),
    .attaboy_taken_o            (attaboy_taken_o),
    .attaboy_ntaken_o           (attaboy_ntaken_o),
    .attaboy_yumi_i             (attaboy_yumi_i)
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
    ,.attaboy_drop_cnt_o        (attaboy_drop_cnt_o)
`endif
  );

  // 10 ns clock; inputs change and outputs are sampled 1 ns after posedge.
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearInputs();
    commit_v_i               = 1'b0;
    commit_npc_i             = '0;
    commit_br_metadata_fwd_i = '0;
    commit_taken_i           = 1'b0;
    commit_mispredict_i      = 1'b0;
    commit_nonbr_i           = 1'b0;
    ext_redirect_v_i         = 1'b0;
    ext_redirect_pc_i        = '0;
    attaboy_yumi_i           = 1'b0;
  endtask

  task automatic driveCommit(input logic [VW-1:0] npc, input logic [MW-1:0] md,
                             input logic taken, input logic mispredict, input logic nonbr);
    commit_v_i               = 1'b1;
    commit_npc_i             = npc;
    commit_br_metadata_fwd_i = md;
    commit_taken_i           = taken;
    commit_mispredict_i      = mispredict;
    commit_nonbr_i           = nonbr;
  endtask

  // Reset holds every output at zero.
  task automatic test_reset();
    clearInputs();
    fe_init_done_i = 1'b0;
    reset_n_i = 1'b0;
    repeat (3) tick();
    checkCount++; if (redirect_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_redirect_v got %0b want 0", redirect_v_o); end
    checkCount++; if (redirect_pc_o !== '0) begin errorCount++; $display("[TB] FAIL rst_redirect_pc got %0h want 0", redirect_pc_o); end
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_attaboy_v got %0b want 0", attaboy_v_o); end
    checkCount++; if (attaboy_pc_o !== '0) begin errorCount++; $display("[TB] FAIL rst_attaboy_pc got %0h want 0", attaboy_pc_o); end
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
    checkCount++; if (attaboy_drop_cnt_o !== 8'd0) begin errorCount++; $display("[TB] FAIL rst_drop_cnt got %0d want 0", attaboy_drop_cnt_o); end
`endif
    reset_n_i = 1'b1;
  endtask

  // Attaboys collect during init wait but appear only once init is done.
  task automatic test_init_gating();
    logic [VW-1:0] expPc [3];
    logic [MW-1:0] expMd [3];
    logic          expTaken [3];
    logic          expNtaken [3];
    expPc[0] = 39'h0000_1000; expMd[0] = MD_BR  | 24'h000100; expTaken[0] = 1'b1; expNtaken[0] = 1'b0;
    expPc[1] = 39'h0000_2000; expMd[1] = MD_JAL | 24'h000200; expTaken[1] = 1'b1; expNtaken[1] = 1'b0;
    expPc[2] = 39'h0000_3000; expMd[2] = MD_BR  | 24'h000300; expTaken[2] = 1'b0; expNtaken[2] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      driveCommit(expPc[i], expMd[i], expTaken[i], 1'b0, 1'b0);
      tick();
      checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL init_hold_commit%0d attaboy_v got %0b want 0", i, attaboy_v_o); end
    end
    clearInputs();
    for (int i = 0; i < 7; i++) begin
      tick();
      checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL init_hold_idle%0d attaboy_v got %0b want 0", i, attaboy_v_o); end
    end
    fe_init_done_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkCount++; if (attaboy_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL init_pop%0d_v got %0b want 1", i, attaboy_v_o); end
      checkCount++; if (attaboy_pc_o !== expPc[i]) begin errorCount++; $display("[TB] FAIL init_pop%0d_pc got %0h want %0h", i, attaboy_pc_o, expPc[i]); end
      checkCount++; if (attaboy_br_metadata_fwd_o !== expMd[i]) begin errorCount++; $display("[TB] FAIL init_pop%0d_md got %0h want %0h", i, attaboy_br_metadata_fwd_o, expMd[i]); end
      checkCount++; if (attaboy_taken_o !== expTaken[i]) begin errorCount++; $display("[TB] FAIL init_pop%0d_taken got %0b want %0b", i, attaboy_taken_o, expTaken[i]); end
      checkCount++; if (attaboy_ntaken_o !== expNtaken[i]) begin errorCount++; $display("[TB] FAIL init_pop%0d_ntaken got %0b want %0b", i, attaboy_ntaken_o, expNtaken[i]); end
      attaboy_yumi_i = 1'b1;
      tick();
      attaboy_yumi_i = 1'b0;
    end
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL init_empty attaboy_v got %0b want 0", attaboy_v_o); end
  endtask

  // Taken branch mispredict gives a one-cycle branch redirect.
  task automatic test_mispredict_taken();
    driveCommit(39'h0_8000_0040, MD_BR | 24'h00AB00, 1'b1, 1'b1, 1'b0);
    tick();
    clearInputs();
    checkCount++; if (redirect_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL mp_v got %0b want 1", redirect_v_o); end
    checkCount++; if (redirect_pc_o !== 39'h0_8000_0040) begin errorCount++; $display("[TB] FAIL mp_pc got %0h want 80000040", redirect_pc_o); end
    checkCount++; if (redirect_br_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL mp_br_v got %0b want 1", redirect_br_v_o); end
    checkCount++; if (redirect_br_metadata_fwd_o !== 24'h00AB01) begin errorCount++; $display("[TB] FAIL mp_md got %0h want 00ab01", redirect_br_metadata_fwd_o); end
    checkCount++; if (redirect_br_taken_o !== 1'b1) begin errorCount++; $display("[TB] FAIL mp_taken got %0b want 1", redirect_br_taken_o); end
    checkCount++; if (redirect_br_ntaken_o !== 1'b0) begin errorCount++; $display("[TB] FAIL mp_ntaken got %0b want 0", redirect_br_ntaken_o); end
    checkCount++; if (redirect_br_nonbr_o !== 1'b0) begin errorCount++; $display("[TB] FAIL mp_nonbr got %0b want 0", redirect_br_nonbr_o); end
    tick();
    checkCount++; if (redirect_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL mp_pulse_end got %0b want 0", redirect_v_o); end
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL mp_no_attaboy got %0b want 0", attaboy_v_o); end
  endtask

  // Non-branch mispredict flags nonbr and clears taken/ntaken; a not-taken
  // branch mispredict reports ntaken.
  task automatic test_nonbr();
    driveCommit(39'h0_0000_5000, MD_NONE, 1'b1, 1'b1, 1'b1);
    tick();
    clearInputs();
    checkCount++; if (redirect_br_nonbr_o !== 1'b1) begin errorCount++; $display("[TB] FAIL nonbr_flag got %0b want 1", redirect_br_nonbr_o); end
    checkCount++; if (redirect_br_taken_o !== 1'b0) begin errorCount++; $display("[TB] FAIL nonbr_taken got %0b want 0", redirect_br_taken_o); end
    checkCount++; if (redirect_br_ntaken_o !== 1'b0) begin errorCount++; $display("[TB] FAIL nonbr_ntaken got %0b want 0", redirect_br_ntaken_o); end
    checkCount++; if (redirect_pc_o !== 39'h0_0000_5000) begin errorCount++; $display("[TB] FAIL nonbr_pc got %0h want 5000", redirect_pc_o); end
    driveCommit(39'h0_0000_6000, MD_BR, 1'b0, 1'b1, 1'b0);
    tick();
    clearInputs();
    checkCount++; if (redirect_br_ntaken_o !== 1'b1) begin errorCount++; $display("[TB] FAIL nt_ntaken got %0b want 1", redirect_br_ntaken_o); end
    checkCount++; if (redirect_br_taken_o !== 1'b0) begin errorCount++; $display("[TB] FAIL nt_taken got %0b want 0", redirect_br_taken_o); end
    checkCount++; if (redirect_br_nonbr_o !== 1'b0) begin errorCount++; $display("[TB] FAIL nt_nonbr got %0b want 0", redirect_br_nonbr_o); end
    tick();
  endtask

  // External redirect wins over a simultaneous mispredict.
  task automatic test_ext_priority();
    driveCommit(39'h0_8000_0040, MD_BR, 1'b1, 1'b1, 1'b0);
    ext_redirect_v_i  = 1'b1;
    ext_redirect_pc_i = 39'h0_0000_1000;
    tick();
    clearInputs();
    checkCount++; if (redirect_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL ext_v got %0b want 1", redirect_v_o); end
    checkCount++; if (redirect_pc_o !== 39'h0_0000_1000) begin errorCount++; $display("[TB] FAIL ext_pc got %0h want 1000", redirect_pc_o); end
    checkCount++; if (redirect_br_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL ext_br_v got %0b want 0", redirect_br_v_o); end
    checkCount++; if (redirect_br_taken_o !== 1'b0) begin errorCount++; $display("[TB] FAIL ext_taken got %0b want 0", redirect_br_taken_o); end
    checkCount++; if (redirect_br_metadata_fwd_o !== '0) begin errorCount++; $display("[TB] FAIL ext_md got %0h want 0", redirect_br_metadata_fwd_o); end
    tick();
    checkCount++; if (redirect_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL ext_pulse_end got %0b want 0", redirect_v_o); end
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL ext_no_attaboy got %0b want 0", attaboy_v_o); end
  endtask

  // Six commits into a 4-deep queue drop two; a 7th with a pop is accepted.
  task automatic test_overflow();
    logic [VW-1:0] expPc [4];
    for (int i = 0; i < 6; i++) begin
      driveCommit(39'h100 + 39'(i * 4), MD_BR, 1'b1, 1'b0, 1'b0);
      tick();
    end
    clearInputs();
    checkCount++; if (attaboy_pc_o !== 39'h100) begin errorCount++; $display("[TB] FAIL ovf_head got %0h want 100", attaboy_pc_o); end
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
    checkCount++; if (attaboy_drop_cnt_o !== 8'd2) begin errorCount++; $display("[TB] FAIL ovf_drop_cnt got %0d want 2", attaboy_drop_cnt_o); end
`endif
    driveCommit(39'h200, MD_BR, 1'b1, 1'b0, 1'b0);
    attaboy_yumi_i = 1'b1;
    tick();
    clearInputs();
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
    checkCount++; if (attaboy_drop_cnt_o !== 8'd2) begin errorCount++; $display("[TB] FAIL ovf_drop_cnt7 got %0d want 2", attaboy_drop_cnt_o); end
`endif
    expPc[0] = 39'h104; expPc[1] = 39'h108; expPc[2] = 39'h10C; expPc[3] = 39'h200;
    for (int i = 0; i < 4; i++) begin
      checkCount++; if (attaboy_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL ovf_pop%0d_v got %0b want 1", i, attaboy_v_o); end
      checkCount++; if (attaboy_pc_o !== expPc[i]) begin errorCount++; $display("[TB] FAIL ovf_pop%0d_pc got %0h want %0h", i, attaboy_pc_o, expPc[i]); end
      if (attaboy_v_o === 1'b1) attaboy_yumi_i = 1'b1;
      tick();
      attaboy_yumi_i = 1'b0;
    end
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL ovf_empty got %0b want 0", attaboy_v_o); end
  endtask

  // Reset during a pop with a pending redirect clears everything at once.
  task automatic test_reset_mid_pop();
    for (int i = 0; i < 3; i++) begin
      driveCommit(39'h400 + 39'(i * 4), MD_BR, 1'b1, 1'b0, 1'b0);
      tick();
    end
    driveCommit(39'h0_0000_7000, MD_BR, 1'b1, 1'b1, 1'b0);
    tick();
    clearInputs();
    checkCount++; if (redirect_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL rmp_pre_redirect got %0b want 1", redirect_v_o); end
    checkCount++; if (attaboy_v_o !== 1'b1) begin errorCount++; $display("[TB] FAIL rmp_pre_attaboy got %0b want 1", attaboy_v_o); end
    attaboy_yumi_i = 1'b1;
    reset_n_i = 1'b0;
    #1;
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL rmp_attaboy_v got %0b want 0", attaboy_v_o); end
    checkCount++; if (redirect_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL rmp_redirect_v got %0b want 0", redirect_v_o); end
    checkCount++; if (redirect_pc_o !== '0) begin errorCount++; $display("[TB] FAIL rmp_redirect_pc got %0h want 0", redirect_pc_o); end
`ifdef BP_BE_ATTABOY_DROP_CNT_EN
    checkCount++; if (attaboy_drop_cnt_o !== 8'd0) begin errorCount++; $display("[TB] FAIL rmp_drop_cnt got %0d want 0", attaboy_drop_cnt_o); end
`endif
    attaboy_yumi_i = 1'b0;
    repeat (2) tick();
    reset_n_i = 1'b1;
    repeat (2) tick();
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL rmp_post_empty got %0b want 0", attaboy_v_o); end
    driveCommit(39'h300, MD_JAL, 1'b1, 1'b0, 1'b0);
    tick();
    clearInputs();
    checkCount++; if (attaboy_pc_o !== 39'h300) begin errorCount++; $display("[TB] FAIL rmp_post_head got %0h want 300", attaboy_pc_o); end
    if (attaboy_v_o === 1'b1) attaboy_yumi_i = 1'b1;
    tick();
    attaboy_yumi_i = 1'b0;
    checkCount++; if (attaboy_v_o !== 1'b0) begin errorCount++; $display("[TB] FAIL rmp_post_drain got %0b want 0", attaboy_v_o); end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_mispredict_taken();
    test_nonbr();
    test_ext_priority();
    test_overflow();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/bp_be_br_feedback_gen.md
BP_BE_BR_FEEDBACK_GEN -- requirements
Module: bp_be_br_feedback_gen

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg: processor config; supplies vaddr_width_p and branch_metadata_fwd_width_p.
REQ-002 SHALL have parameter attaboy_els_p, default 4: attaboy queue depth, power of two, at least 2.
REQ-003 SHALL have parameter drop_cnt_width_p, default 8: drop counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk_i input 1, the sole clock; reset_n_i input 1, asynchronous active-low reset.
REQ-005 SHALL have port fe_init_done_i, input, 1 bit: frontend predictor init complete.
REQ-006 SHALL have commit ports: commit_v_i (1), commit_npc_i (vaddr), commit_br_metadata_fwd_i (metadata), commit_taken_i (1), commit_mispredict_i (1), commit_nonbr_i (1; the frontend predicted this site but it is not a control-flow instruction).
REQ-007 SHALL have external redirect ports: ext_redirect_v_i (1) and ext_redirect_pc_i (vaddr), used for trap/CSR/fence redirects.
REQ-008 SHALL have redirect outputs: redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_metadata_fwd_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o.
REQ-009 SHALL have attaboy outputs attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o, attaboy_taken_o, attaboy_ntaken_o, plus input attaboy_yumi_i (1).
REQ-010 SHALL have output attaboy_drop_cnt_o, drop_cnt_width_p bits, present only when the macro in REQ-025 is defined.

Function
REQ-011 SHALL define a control-flow site as any of metadata site_br, site_jal, site_jalr, or commit_nonbr_i.
REQ-012 SHALL register all redirect outputs and pulse redirect_v_o for exactly 1 cycle, 1 cycle after the triggering input.
REQ-013 On ext_redirect_v_i, SHALL drive redirect_pc_o = ext_redirect_pc_i, redirect_br_v_o = 0, and all br flags = 0.
REQ-014 On commit_v_i & commit_mispredict_i without an external redirect, SHALL drive:
- redirect_pc_o = commit_npc_i
- redirect_br_v_o = 1
- metadata passed through
- taken = commit_taken_i & ~nonbr
- ntaken = ~commit_taken_i & ~nonbr & site_br
- nonbr = commit_nonbr_i
REQ-015 When both redirect sources fire in the same cycle, the external redirect SHALL win and the branch information SHALL be discarded; no attaboy is enqueued.
REQ-016 On commit_v_i & ~commit_mispredict_i & site_br|site_jal|site_jalr, SHALL enqueue the entry {npc, metadata, taken, ntaken = ~taken & site_br}.
REQ-017 attaboy_v_o SHALL equal (queue not empty) & (state == e_fbgen_run); the head entry SHALL be held stable until attaboy_yumi_i.
REQ-018 attaboy_yumi_i SHALL pop the head in the same cycle; yumi without valid is illegal and asserted in simulation.
REQ-019 Queue ordering SHALL be FIFO.
- Enqueue and dequeue in the same cycle while full: both proceed.
- Enqueue while full with no dequeue: the new entry is dropped.
REQ-020 Redirects SHALL NOT flush the queue.
REQ-021 SHALL implement an FSM with states e_fbgen_reset, e_fbgen_wait_init, e_fbgen_run:
- e_fbgen_reset -> e_fbgen_wait_init, 1 cycle after reset deassertion.
- e_fbgen_wait_init -> e_fbgen_run when fe_init_done_i = 1.
- e_fbgen_run is terminal until reset.
REQ-022 Redirects SHALL be issued in every state except e_fbgen_reset; enqueue SHALL be allowed in e_fbgen_wait_init.

Reset
REQ-023 Asserting reset_n_i low at any time SHALL immediately:
- clear all outputs to 0
- empty the queue
- zero the drop counter
- place the FSM in e_fbgen_reset
Any in-flight redirect SHALL be lost.

Configuration
REQ-024 Without the macro in REQ-025, dropped attaboys SHALL be silently discarded and no counter logic SHALL exist.
REQ-025 With BP_BE_ATTABOY_DROP_CNT_EN defined, SHALL add a saturating counter that increments per dropped attaboy, holds at all-ones, and drives attaboy_drop_cnt_o.

Structure
REQ-026 SHALL place the enum bp_be_fbgen_state_e and the attaboy entry struct macro in bp_be_pkg.
REQ-027 SHALL implement the queue as sub-module bp_be_attaboy_fifo (async active-low reset, 1r1w, valid/yumi output).

Verification
REQ-028 Bench SHALL cover: reset release with fe_init_done_i = 0 for 10 cycles and 3 correct commits -> attaboy_v_o = 0 throughout; set init_done -> attaboy_v_o = 1 within 1 cycle, 3 pops in order.
REQ-029 Bench SHALL cover: mispredicted taken branch with npc = 0x8000_0040, site_br = 1 -> next cycle redirect_v_o = 1, pc = 0x8000_0040, br_v = 1, taken = 1, ntaken = 0, single-cycle pulse.
REQ-030 Bench SHALL cover: commit_nonbr_i with mispredict -> redirect_br_nonbr_o = 1, taken = ntaken = 0.
REQ-031 Bench SHALL cover: ext_redirect pc = 0x1000 concurrent with a branch mispredict -> redirect_pc_o = 0x1000, br_v = 0.
REQ-032 Bench SHALL cover: 6 correct commits with depth 4 and no yumi -> 4 entries held, 2 dropped, drop count = 2 with the macro defined; a 7th commit with simultaneous yumi is accepted.
REQ-033 Bench SHALL cover: reset asserted with 3 queued entries mid-pop -> attaboy_v_o = 0 immediately and the queue is empty after release.
